// File: rtl/cu_pkg.sv
// Shared stage encoding for the control unit and its stage monitor.
package cu_pkg;

   localparam int unsigned NUM_STAGES = 6;

   localparam logic [2:0] ST_FETCH = 3'd0;
   localparam logic [2:0] ST_DEC   = 3'd1;
   localparam logic [2:0] ST_RGRD  = 3'd2;
   localparam logic [2:0] ST_ALU   = 3'd3;
   localparam logic [2:0] ST_RGWR  = 3'd4;
   localparam logic [2:0] ST_MEM   = 3'd5;
   localparam logic [2:0] ST_NONE  = 3'd7;

   typedef enum logic {StUnsync, StSync} mon_state_e;

   function automatic logic [2:0] next_stage(input logic [2:0] s);
      return (s == ST_MEM) ? ST_FETCH : s + 3'd1;
   endfunction

endpackage

// File: rtl/cu_stage_decode.sv
// Combinational decode of the six stage enables into {legal, stage}.
module cu_stage_decode
   import cu_pkg::*;
(
   input  logic       enfetch,
   input  logic       endec,
   input  logic       enrgrd,
   input  logic       enalu,
   input  logic       enrgwr,
   input  logic       enmem,
   output logic       legal,
   output logic [2:0] stage
);

   logic [5:0] hot;

   always_comb begin
      // enrgrd stays high during rgwr, so the pair splits into two stages
      hot   = {enmem, enrgrd & enrgwr, enalu, enrgrd & ~enrgwr, endec, enfetch};
      legal = $onehot(hot) && !(enrgwr && !enrgrd);
      stage = ST_NONE;
      if (legal) begin
         for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (hot[i]) stage = 3'(i);
         end
      end
   end

endmodule

// File: rtl/cu_stage_monitor.sv
// Stage-enable monitor: order checking, retire counting and sticky errors.
// Optional hold tolerance is built when STAGE_MON_HOLD_EN is defined.
module cu_stage_monitor
   import cu_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enfetch,
   input  logic             endec,
   input  logic             enrgrd,
   input  logic             enalu,
   input  logic             enrgwr,
   input  logic             enmem,
   input  logic             clear_err,
   output logic [2:0]       stage_cur,
   output logic             synced,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic             err_encoding,
   output logic             err_order,
   output logic             err_hold,
   output logic             err_any
);

   logic             legal;
   logic [2:0]       stage;
   mon_state_e       state_q, state_d;
   logic [2:0]       exp_q, exp_d;
   logic             retire_d;
   logic [CNT_W-1:0] count_d;
   logic             new_enc, new_ord, new_hold;
   logic             repeat_st, hold_over;

   cu_stage_decode u_decode (
      .enfetch (enfetch),
      .endec   (endec),
      .enrgrd  (enrgrd),
      .enalu   (enalu),
      .enrgwr  (enrgwr),
      .enmem   (enmem),
      .legal   (legal),
      .stage   (stage)
   );

`ifdef STAGE_MON_HOLD_EN
   localparam int unsigned HoldW = $clog2(HOLD_MAX + 2);
   logic [HoldW-1:0] hold_q, hold_d;

   always_comb begin
      repeat_st = legal && (stage == stage_cur);
      hold_d    = '0;
      if (repeat_st) begin
         hold_d = (hold_q == HoldW'(HOLD_MAX + 1)) ? hold_q : hold_q + 1'b1;
      end
      hold_over = hold_d > HoldW'(HOLD_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) hold_q <= '0;
      else     hold_q <= hold_d;
   end

   always_ff @(posedge clk) begin
      if (rst) err_hold <= 1'b0;
      else     err_hold <= (err_hold & ~clear_err) | new_hold;
   end
`else
   logic unused_hold;
   assign repeat_st   = 1'b0;
   assign hold_over   = 1'b0;
   assign err_hold    = 1'b0;
   assign unused_hold = new_hold | (HOLD_MAX != 0);
`endif

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      retire_d = 1'b0;
      count_d  = instr_count;
      new_enc  = 1'b0;
      new_ord  = 1'b0;
      new_hold = 1'b0;
      if (!legal) begin
         new_enc = 1'b1;
         state_d = StUnsync;
         exp_d   = ST_FETCH;
      end else if (state_q == StUnsync) begin
         if (stage == ST_FETCH) begin
            state_d = StSync;
            exp_d   = next_stage(ST_FETCH);
         end
      end else if (stage == exp_q) begin
         exp_d = next_stage(exp_q);
         if (stage == ST_MEM) begin
            retire_d = 1'b1;
            count_d  = instr_count + 1'b1;
         end
      end else if (repeat_st) begin
         if (hold_over) begin
            new_hold = 1'b1;
            state_d  = StUnsync;
            exp_d    = ST_FETCH;
         end
      end else begin
         new_ord = 1'b1;
         // An unexpected FETCH starts a fresh instruction immediately
         if (stage == ST_FETCH) begin
            state_d = StSync;
            exp_d   = next_stage(ST_FETCH);
         end else begin
            state_d = StUnsync;
            exp_d   = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StUnsync;
         exp_q        <= ST_FETCH;
         stage_cur    <= ST_NONE;
         retire       <= 1'b0;
         instr_count  <= '0;
         err_encoding <= 1'b0;
         err_order    <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         stage_cur    <= stage;
         retire       <= retire_d;
         instr_count  <= count_d;
         err_encoding <= (err_encoding & ~clear_err) | new_enc;
         err_order    <= (err_order & ~clear_err) | new_ord;
      end
   end

   assign synced  = (state_q == StSync);
   assign err_any = err_encoding | err_order | err_hold;

endmodule

// File: tb/tb_cu_stage_monitor.sv
// Randomised bench for cu_stage_monitor with a behavioural reference model.
module tb_cu_stage_monitor;

   localparam int unsigned CNT_W    = 4;
   localparam int unsigned HOLD_MAX = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enfetch = 0, endec = 0, enrgrd = 0, enalu = 0, enrgwr = 0, enmem = 0;
   logic             clear_err = 0;
   logic [2:0]       stage_cur;
   logic             synced, retire, err_encoding, err_order, err_hold, err_any;
   logic [CNT_W-1:0] instr_count;

   cu_stage_monitor #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)) dut (
      .clk          (clk),
      .rst          (rst),
      .enfetch      (enfetch),
      .endec        (endec),
      .enrgrd       (enrgrd),
      .enalu        (enalu),
      .enrgwr       (enrgwr),
      .enmem        (enmem),
      .clear_err    (clear_err),
      .stage_cur    (stage_cur),
      .synced       (synced),
      .retire       (retire),
      .instr_count  (instr_count),
      .err_encoding (err_encoding),
      .err_order    (err_order),
      .err_hold     (err_hold),
      .err_any      (err_any)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ret   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stage numbers as plain ints, expected stage advances modulo 6
   int m_stage = 7, m_exp = 0, m_count = 0, m_hold = 0;
   bit m_synced = 0, m_retire = 0, m_enc = 0, m_ord = 0, m_hld = 0;
   bit started = 0;

   always @(posedge clk) begin
      int  st, hold_new, ones;
      bit  ok, rep, e_enc, e_ord, e_hld, ret;
      started = 1;
      if (rst) begin
         m_stage = 7; m_exp = 0; m_count = 0; m_hold = 0;
         m_synced = 0; m_retire = 0; m_enc = 0; m_ord = 0; m_hld = 0;
      end else begin
         e_enc = 0; e_ord = 0; e_hld = 0; ret = 0;
         ones = int'(enfetch) + int'(endec) + int'(enrgrd) + int'(enalu) + int'(enmem);
         ok = (ones == 1) && !(enrgwr && !enrgrd);
         st = enfetch ? 0 : endec ? 1 : enrgrd ? (enrgwr ? 4 : 2) : enalu ? 3 : 5;
         if (!ok) begin
            st = 7; e_enc = 1; m_synced = 0; m_exp = 0; m_hold = 0;
         end else begin
            rep = (st == m_stage);
            hold_new = rep ? ((m_hold + 1 > HOLD_MAX + 1) ? HOLD_MAX + 1 : m_hold + 1) : 0;
            if (!m_synced) begin
               if (st == 0) begin m_synced = 1; m_exp = 1; end
            end else if (st == m_exp) begin
               if (st == 5) begin
                  ret = 1;
                  m_count = (m_count + 1) % (1 << CNT_W);
               end
               m_exp = (m_exp + 1) % 6;
            end
`ifdef STAGE_MON_HOLD_EN
            else if (rep) begin
               if (hold_new > HOLD_MAX) begin e_hld = 1; m_synced = 0; m_exp = 0; end
            end
`endif
            else begin
               e_ord = 1;
               if (st == 0) m_exp = 1;
               else begin m_synced = 0; m_exp = 0; end
            end
            m_hold = hold_new;
         end
         m_stage  = st;
         m_retire = ret;
         m_enc = (m_enc && !clear_err) || e_enc;
         m_ord = (m_ord && !clear_err) || e_ord;
         m_hld = (m_hld && !clear_err) || e_hld;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("stage_cur", 32'(stage_cur), 32'(m_stage));
         check("synced", 32'(synced), 32'(m_synced));
         check("retire", 32'(retire), 32'(m_retire));
         check("instr_count", 32'(instr_count), 32'(m_count));
         check("err_encoding", 32'(err_encoding), 32'(m_enc));
         check("err_order", 32'(err_order), 32'(m_ord));
         check("err_hold", 32'(err_hold), 32'(m_hld));
         check("err_any", 32'(err_any), 32'(m_enc || m_ord || m_hld));
      end
   end

   // Bit order {enmem, enrgwr, enalu, enrgrd, endec, enfetch}
   function automatic logic [5:0] enc(input int s);
      logic [5:0] v;
      case (s)
         0:       v = 6'b000001;
         1:       v = 6'b000010;
         2:       v = 6'b000100;
         3:       v = 6'b001000;
         4:       v = 6'b010100;
         default: v = 6'b100000;
      endcase
      return v;
   endfunction

   task automatic apply(input logic [5:0] v, input bit clr);
      {enmem, enrgwr, enalu, enrgrd, endec, enfetch} = v;
      clear_err = clr;
      @(negedge clk);
      if (retire) n_ret++;
   endtask

   task automatic instr();
      for (int s = 0; s < 6; s++) apply(enc(s), 0);
   endtask

   initial begin
      int nxt, p, s;
      rst = 1;
      apply(6'b0, 0);
      apply(6'b0, 0);
      check("reset stage_cur", 32'(stage_cur), 7);
      check("reset synced", 32'(synced), 0);
      check("reset instr_count", 32'(instr_count), 0);
      check("reset err_any", 32'(err_any), 0);
      rst = 0;

      // Three clean instructions
      n_ret = 0;
      apply(enc(0), 0);
      check("synced after first fetch", 32'(synced), 1);
      for (int s2 = 1; s2 < 6; s2++) apply(enc(s2), 0);
      instr();
      instr();
      check("three retires", 32'(n_ret), 3);
      check("count after three", 32'(instr_count), 3);
      check("clean err_any", 32'(err_any), 0);

      // enrgwr without enrgrd
      apply(6'b010000, 0);
      check("enc err flag", 32'(err_encoding), 1);
      check("enc err synced", 32'(synced), 0);
      check("enc err stage_cur", 32'(stage_cur), 7);
      apply(enc(0), 0);
      check("resync after enc err", 32'(synced), 1);
      for (int s2 = 1; s2 < 6; s2++) apply(enc(s2), 0);
      check("count after resync", 32'(instr_count), 4);

      // DEC followed straight by ALU
      n_ret = 0;
      apply(enc(0), 1);
      apply(enc(1), 0);
      apply(enc(3), 0);
      check("skip err_order", 32'(err_order), 1);
      check("skip synced", 32'(synced), 0);
      apply(enc(2), 0);
      apply(enc(4), 0);
      apply(enc(5), 0);
      check("no retire while unsynced", 32'(n_ret), 0);
      instr();
      check("count after recovery", 32'(instr_count), 5);

      // FETCH injected after ALU
      for (int s2 = 0; s2 < 4; s2++) apply(enc(s2), s2 == 0);
      apply(enc(0), 0);
      check("inject err_order", 32'(err_order), 1);
      check("inject synced", 32'(synced), 1);
      for (int s2 = 1; s2 < 6; s2++) apply(enc(s2), 0);
      check("count after inject", 32'(instr_count), 6);

      // Counter wrap, then clear colliding with a new encoding error
      for (int i = 0; i < 10; i++) instr();
      check("count wrap", 32'(instr_count), 0);
      apply(6'b000011, 1);
      check("new error beats clear", 32'(err_encoding), 1);
      apply(enc(0), 1);
      check("clear err_any", 32'(err_any), 0);

`ifdef STAGE_MON_HOLD_EN
      apply(enc(1), 0);
      apply(enc(2), 0);
      for (int i = 0; i < 5; i++) apply(enc(3), 0);
      apply(enc(4), 0);
      apply(enc(5), 0);
      check("hold 5 no error", 32'(err_any), 0);
      check("hold 5 retired", 32'(instr_count), 1);
      for (int s2 = 0; s2 < 3; s2++) apply(enc(s2), 0);
      for (int i = 0; i < 6; i++) apply(enc(3), 0);
      check("hold 6 err_hold", 32'(err_hold), 1);
`else
      apply(enc(1), 0);
      apply(enc(2), 0);
      apply(enc(3), 0);
      apply(enc(3), 0);
      check("repeat err_order", 32'(err_order), 1);
      check("repeat err_hold", 32'(err_hold), 0);
`endif

      // Random phase, mostly legal progression with injected faults
      nxt = 0;
      for (int i = 0; i < 3000; i++) begin
         p = $urandom_range(0, 999);
         rst = (p < 5);
         p = $urandom_range(0, 99);
         if (p < 85) begin
            apply(enc(nxt), $urandom_range(0, 99) < 5);
            nxt = (nxt + 1) % 6;
         end else if (p < 91) begin
            apply(enc((nxt + 5) % 6), $urandom_range(0, 99) < 5);
         end else if (p < 96) begin
            s = $urandom_range(0, 5);
            apply(enc(s), $urandom_range(0, 99) < 5);
            nxt = (s + 1) % 6;
         end else begin
            apply(6'($urandom), $urandom_range(0, 99) < 5);
         end
      end
      rst = 0;
      apply(6'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
